dcsr_debug_ctrl: RTL



---
 rtl/dcsr_pkg.sv | 36 +++
 rtl/dcsr_entry_arb.sv | 23 ++
 rtl/dcsr_debug_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dcsr_pkg.sv
// rtl/dcsr_pkg.sv - shared types, constants and dcsr bit positions for the debug controller
package dcsr_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EBREAK  = 3'd1,
    CAUSE_TRIGGER = 3'd2,
    CAUSE_HALTREQ = 3'd3,
    CAUSE_STEP    = 3'd4
  } dcsr_cause_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STEP,
    ST_DEBUG,
    ST_RESUMING
  } dbg_state_e;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_M = 2'd3;

  localparam int XDEBUGVER_LSB = 28;
  localparam int EBREAKM_BIT   = 15;
  localparam int EBREAKU_BIT   = 12;
  localparam int STOPCYCLE_BIT = 10;
  localparam int STOPTIME_BIT  = 9;
  localparam int CAUSE_LSB     = 6;
  localparam int STEP_BIT      = 2;
  localparam int PRV_LSB       = 0;

  // prv is WARL: the unsupported encodings 1 and 2 leave the old value in place
  function automatic logic [1:0] warl_prv(input logic [1:0] old_prv, input logic [1:0] new_prv);
    return ((new_prv == 2'd1) || (new_prv == 2'd2)) ? old_prv : new_prv;
  endfunction

endpackage

// File: rtl/dcsr_entry_arb.sv
// rtl/dcsr_entry_arb.sv - fixed-priority selection of the debug-entry cause
module dcsr_entry_arb
  import dcsr_pkg::*;
(
  input  logic       trigger_hit_i,
  input  logic       ebreak_en_i,
  input  logic       haltreq_i,
  input  logic       step_done_i,
  output logic       take_debug_o,
  output logic [2:0] cause_o
);

  always_comb begin
    take_debug_o = 1'b1;
    cause_o      = CAUSE_NONE;
    if (trigger_hit_i)      cause_o = CAUSE_TRIGGER;
    else if (ebreak_en_i)   cause_o = CAUSE_EBREAK;
    else if (haltreq_i)     cause_o = CAUSE_HALTREQ;
    else if (step_done_i)   cause_o = CAUSE_STEP;
    else                    take_debug_o = 1'b0;
  end

endmodule

// File: rtl/dcsr_debug_ctrl.sv
// rtl/dcsr_debug_ctrl.sv - dcsr register and hart debug-mode state machine
module dcsr_debug_ctrl
  import dcsr_pkg::*;
#(
  parameter logic [3:0] XDEBUGVER = 4'd4,
  parameter logic [1:0] RESET_PRV = 2'd3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        haltreq,
  input  logic        resumereq,
  input  logic        ebreak_valid,
  input  logic        trigger_hit,
  input  logic        retire_valid,
  input  logic [1:0]  cur_prv,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic        debug_mode,
  output logic        enter_debug,
  output logic        resume_ack,
  output logic [1:0]  resume_prv,
  output logic [31:0] dcsr_rdata,
  output logic [1:0]  prv,
  output logic        step,
  output logic [2:0]  cause,
  output logic        stoptime,
  output logic        stopcycle,
  output logic        ebreaku,
  output logic        ebreakm,
  output logic        ebreaks,
  output logic        ebreakh,
  output logic [1:0]  xdebugver
);

  dbg_state_e state_q, state_d;
  logic [1:0] prv_q, prv_d, resume_prv_q, resume_prv_d;
  logic [2:0] cause_q, cause_d;
  logic       step_q, step_d, stoptime_q, stoptime_d, stopcycle_q, stopcycle_d;
  logic       ebreaku_q, ebreaku_d, ebreakm_q, ebreakm_d, enter_q, enter_d;

  logic       evt_window, ebreak_en, take_debug;
  logic [2:0] arb_cause;
  logic       unused_wdata;

  assign unused_wdata = ^{csr_wdata[31:16], csr_wdata[14:13], csr_wdata[11], csr_wdata[8:3]};

  // Entry events only count while the hart is executing (RUN or single-step)
  assign evt_window = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign ebreak_en  = ebreak_valid && (((cur_prv == PRV_M) && ebreakm_q) ||
                                       ((cur_prv == PRV_U) && ebreaku_q));

  dcsr_entry_arb u_entry_arb (
    .trigger_hit_i (evt_window && trigger_hit),
    .ebreak_en_i   (evt_window && ebreak_en),
    .haltreq_i     (evt_window && haltreq),
    .step_done_i   ((state_q == ST_STEP) && retire_valid),
    .take_debug_o  (take_debug),
    .cause_o       (arb_cause)
  );

  always_comb begin
    state_d      = state_q;
    prv_d        = prv_q;
    resume_prv_d = resume_prv_q;
    cause_d      = cause_q;
    step_d       = step_q;
    stoptime_d   = stoptime_q;
    stopcycle_d  = stopcycle_q;
    ebreaku_d    = ebreaku_q;
    ebreakm_d    = ebreakm_q;
    enter_d      = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: begin
        if (take_debug) begin
          state_d = ST_DEBUG;
          cause_d = arb_cause;
          prv_d   = cur_prv;
          enter_d = 1'b1;
        end
      end
      ST_DEBUG: begin
        if (csr_wen) begin
          step_d      = csr_wdata[STEP_BIT];
          stoptime_d  = csr_wdata[STOPTIME_BIT];
          stopcycle_d = csr_wdata[STOPCYCLE_BIT];
          ebreaku_d   = csr_wdata[EBREAKU_BIT];
          ebreakm_d   = csr_wdata[EBREAKM_BIT];
          prv_d       = warl_prv(prv_q, csr_wdata[PRV_LSB +: 2]);
        end
        // A write in the same cycle as resume must be visible to the resume
        if (resumereq) begin
          state_d      = ST_RESUMING;
          resume_prv_d = prv_d;
        end
      end
      ST_RESUMING: state_d = step_q ? ST_STEP : ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      prv_q        <= RESET_PRV;
      resume_prv_q <= RESET_PRV;
      cause_q      <= CAUSE_NONE;
      step_q       <= 1'b0;
      stoptime_q   <= 1'b0;
      stopcycle_q  <= 1'b0;
      ebreaku_q    <= 1'b0;
      ebreakm_q    <= 1'b0;
      enter_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prv_q        <= prv_d;
      resume_prv_q <= resume_prv_d;
      cause_q      <= cause_d;
      step_q       <= step_d;
      stoptime_q   <= stoptime_d;
      stopcycle_q  <= stopcycle_d;
      ebreaku_q    <= ebreaku_d;
      ebreakm_q    <= ebreakm_d;
      enter_q      <= enter_d;
    end
  end

  assign debug_mode  = (state_q == ST_DEBUG) || (state_q == ST_RESUMING);
  assign enter_debug = enter_q;
  assign resume_ack  = (state_q == ST_RESUMING);
  assign resume_prv  = resume_prv_q;
  assign prv         = prv_q;
  assign step        = step_q;
  assign cause       = cause_q;
  assign stoptime    = stoptime_q;
  assign stopcycle   = stopcycle_q;
  assign ebreaku     = ebreaku_q;
  assign ebreakm     = ebreakm_q;
  assign ebreaks     = 1'b0;
  assign ebreakh     = 1'b0;
  assign xdebugver   = XDEBUGVER[1:0];

  always_comb begin
    dcsr_rdata                               = '0;
    dcsr_rdata[XDEBUGVER_LSB +: 4]           = XDEBUGVER;
    dcsr_rdata[EBREAKM_BIT]                  = ebreakm_q;
    dcsr_rdata[EBREAKU_BIT]                  = ebreaku_q;
    dcsr_rdata[STOPCYCLE_BIT]                = stopcycle_q;
    dcsr_rdata[STOPTIME_BIT]                 = stoptime_q;
    dcsr_rdata[CAUSE_LSB +: 3]               = cause_q;
    dcsr_rdata[STEP_BIT]                     = step_q;
    dcsr_rdata[PRV_LSB +: 2]                 = prv_q;
  end

endmodule
